stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control and sequencing block for the stopwatch time counter (10 ms / second / minute digits). It debounces the two active-low push keys and runs the start/stop/lap/clear state machine. It generates the 10 ms count-enable tick and the clear, lap-latch and display-freeze controls that drive the counter and display path. It does not hold the time digits; it only receives the counter's terminal-count flag.

Parameters:
DIV_10MS, 500000, clk cycles per 10 ms tick (50 MHz clk); bench uses 10
DB_CYCLES, 1000000, consecutive stable cycles for a key level change (20 ms); bench uses 4
DIV_W, 19, width of divider counter (must hold DIV_10MS-1)
DB_W, 20, width of debounce counter (must hold DB_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
key_ss  in  1  raw start/stop key, active-low, asynchronous
key_lc  in  1  raw lap/clear key, active-low, asynchronous
cnt_max  in  1  counter at 59:59.99, level
cnt_en  out  1  one-cycle count-enable pulse to time counter
cnt_clr  out  1  one-cycle synchronous clear pulse to time counter
lap_strobe  out  1  one-cycle pulse: display register captures current time
disp_freeze  out  1  level: display holds captured lap value
state  out  2  00 IDLE, 01 RUN, 10 LAP, 11 STOP

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; cnt_en=cnt_clr=lap_strobe=disp_freeze=0; sync flops and debounced levels=1 (released); all counters=0. Reset mid-operation aborts everything the same way; no clear pulse is issued.
- Key path, per key: two-flop synchronizer, then debounce.
  - Debounce counter counts while the synced level differs from the debounced level; it zeroes when they match.
  - On reaching DB_CYCLES, the debounced level takes the synced value and the counter zeroes.
  - Press event = debounced 1->0, one-cycle pulse; release produces no event.
  - Glitches shorter than DB_CYCLES produce nothing.
  - Pulse appears DB_CYCLES+3 cycles after a clean raw falling edge (+/-1 for async sampling).
- Event priority in one cycle: cnt_max > ss_press > lc_press. A lower-priority event in the same cycle is dropped, not queued.
- State transitions (registered; outputs below are registered with the transition):
  - IDLE: ss -> RUN. lc -> IDLE, cnt_clr=1.
  - RUN: ss -> STOP. lc -> LAP, lap_strobe=1. cnt_max -> STOP.
  - LAP: ss -> STOP, freeze released. lc -> RUN, freeze released. cnt_max -> STOP.
  - STOP: ss -> RUN. lc -> IDLE, cnt_clr=1.
  - cnt_max in IDLE/STOP: ignored.
- disp_freeze = 1 exactly while state==LAP.
- Divider:
  - Held at 0 in IDLE and STOP.
  - In RUN/LAP, counts 0..DIV_10MS-1 and wraps; cnt_en=1 in the cycle the divider is at DIV_10MS-1.
  - The divider is not reset on RUN<->LAP, so counting is continuous through lap.
  - First cnt_en after entering RUN is DIV_10MS cycles after the state change, so resume is exact after a pause.
- cnt_en is never asserted in IDLE or STOP.
- cnt_en and cnt_max in the same cycle: cnt_en still issues; the state goes to STOP next cycle. The counter saturates and does not wrap.
- Holding a key produces exactly one event; a new event requires release, debounce, then press again.

Test Plan:
(DIV_10MS=10, DB_CYCLES=4)
- Reset: hold rst 2 cycles with keys high -> state=00 and all outputs 0; no event after release.
- Start: key_ss low 20 cycles -> state=01 within 7-8 cycles of the raw edge; cnt_en pulses every 10 cycles; first pulse 10 cycles after state=01.
- Glitch reject: key_ss low 2 cycles -> no state change and no cnt_en.
- Lap/unlap: from RUN press lc -> lap_strobe for 1 cycle, state=10, disp_freeze=1, cnt_en period stays 10 with no phase slip. Press lc again -> state=01, disp_freeze=0.
- Stop/clear: RUN, press ss -> state=11, cnt_en stops. Press ss again -> RUN, first cnt_en 10 cycles later. Press ss then lc -> state=00 with a single cnt_clr pulse.
- Simultaneous and overflow: ss and lc pressed together in RUN -> STOP only, no lap_strobe. In LAP, assert cnt_max while pressing lc -> state=11, disp_freeze=0, no cnt_en afterwards.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: key debounce, start/stop/lap/clear FSM, 10 ms tick
// divider and the clear/lap/freeze controls for the time counter and display.

module sw_key_db #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);
    logic [1:0]      sync;
    logic            db;
    logic [DB_W-1:0] cnt;

    // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            db    <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_raw};
            press <= 1'b0;
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                db    <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int unsigned DIV_10MS  = 500000,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DIV_W     = 19,
    parameter int unsigned DB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_ss,
    input  logic       key_lc,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_strobe,
    output logic       disp_freeze,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } st_t;

    localparam int NUM_KEYS = 2;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_press;
    logic                ss, lc;

    assign key_raw = {key_lc, key_ss};
    assign ss      = key_press[0];
    assign lc      = key_press[1];

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            sw_key_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
                .clk     (clk),
                .rst     (rst),
                .key_raw (key_raw[k]),
                .press   (key_press[k])
            );
        end
    endgenerate

    st_t  st_q, st_d;
    logic clr_d, lap_d;

    // cnt_max only matters while counting; in IDLE/STOP the keys still act.
    always_comb begin
        st_d  = st_q;
        clr_d = 1'b0;
        lap_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (ss)      st_d  = RUN;
                else if (lc) clr_d = 1'b1;
            end
            RUN: begin
                if (cnt_max || ss) st_d = STOP;
                else if (lc) begin
                    st_d  = LAP;
                    lap_d = 1'b1;
                end
            end
            LAP: begin
                if (cnt_max || ss) st_d = STOP;
                else if (lc)       st_d = RUN;
            end
            STOP: begin
                if (ss) st_d = RUN;
                else if (lc) begin
                    st_d  = IDLE;
                    clr_d = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_clr     <= 1'b0;
            lap_strobe  <= 1'b0;
            disp_freeze <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_clr     <= clr_d;
            lap_strobe  <= lap_d;
            disp_freeze <= (st_d == LAP);
        end
    end

    // Divider parks at 0 while not counting, so a resume always yields a full period.
    logic [DIV_W-1:0] div;
    logic             running, div_last;

    assign running  = (st_q == RUN) || (st_q == LAP);
    assign div_last = (div == DIV_W'(DIV_10MS - 1));

    always_ff @(posedge clk) begin
        if (rst)                      div <= '0;
        else if (!running || div_last) div <= '0;
        else                          div <= div + 1'b1;
    end

    assign cnt_en = running && div_last;
    assign state  = st_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV_10MS=10, DB_CYCLES=4.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst, key_ss, key_lc, cnt_max;
    logic       cnt_en, cnt_clr, lap_strobe, disp_freeze;
    logic [1:0] state;

    stopwatch_ctrl #(.DIV_10MS(10), .DB_CYCLES(4), .DIV_W(4), .DB_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_ss      (key_ss),
        .key_lc      (key_lc),
        .cnt_max     (cnt_max),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .lap_strobe  (lap_strobe),
        .disp_freeze (disp_freeze),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, st_cyc = 0;
    int n_en = 0, n_lap = 0, n_clr = 0;
    int en_log[$];
    logic [1:0] prev_st = 2'b00;

    // One clock; outputs seen here belong to the cycle after edge 'cyc'.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cnt_en === 1'b1) begin
            n_en++;
            en_log.push_back(cyc);
        end
        if (lap_strobe === 1'b1) n_lap++;
        if (cnt_clr === 1'b1)    n_clr++;
        if (state !== prev_st) begin
            st_cyc  = cyc;
            prev_st = state;
        end
    endtask

    task automatic press(input bit ss, input bit lc, input int low, input int rel);
        if (ss) key_ss = 1'b0;
        if (lc) key_lc = 1'b0;
        repeat (low) step();
        key_ss = 1'b1;
        key_lc = 1'b1;
        repeat (rel) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    int t0, snap, slip;

    initial begin
        rst = 1'b1; key_ss = 1'b1; key_lc = 1'b1; cnt_max = 1'b0;
        step(); step();
        chk("rst_state", 32'(state), 0);
        chk("rst_en", 32'(cnt_en), 0);
        chk("rst_clr", 32'(cnt_clr), 0);
        chk("rst_lap", 32'(lap_strobe), 0);
        chk("rst_frz", 32'(disp_freeze), 0);
        rst = 1'b0;
        n_en = 0; n_lap = 0; n_clr = 0;
        repeat (10) step();
        chk("idle_state", 32'(state), 0);
        chk("idle_no_en", n_en, 0);
        chk("idle_no_clr", n_clr, 0);
        chk("idle_no_lap", n_lap, 0);

        // 2-cycle glitch must not reach the debounced level
        press(1, 0, 2, 12);
        chk("glitch_state", 32'(state), 0);
        chk("glitch_no_en", n_en, 0);

        // Start: held 20 cycles, one event only
        en_log.delete();
        t0 = cyc;
        press(1, 0, 20, 15);
        chk("start_latency", 32'((st_cyc - t0 >= 7) && (st_cyc - t0 <= 8)), 1);
        // state changes at edge st_cyc; first tick is consumed at edge st_cyc+10
        chk("start_first_en", en_log[0] + 1 - st_cyc, 10);
        chk("start_period", en_log[1] - en_log[0], 10);
        chk("start_hold_run", 32'(state), 1);

        // Lap and unlap, tick phase continuous throughout
        en_log.delete();
        n_lap = 0;
        press(0, 1, 8, 10);
        chk("lap_strobe_cnt", n_lap, 1);
        chk("lap_state", 32'(state), 2);
        chk("lap_freeze", 32'(disp_freeze), 1);
        press(0, 1, 8, 10);
        chk("unlap_state", 32'(state), 1);
        chk("unlap_freeze", 32'(disp_freeze), 0);
        slip = 0;
        for (int i = 1; i < en_log.size(); i++)
            if (en_log[i] - en_log[i-1] != 10) slip++;
        chk("lap_no_slip", slip, 0);
        chk("lap_en_seen", 32'(en_log.size() >= 3), 1);

        // Stop, then resume with a full first period
        press(1, 0, 8, 10);
        chk("stop_state", 32'(state), 3);
        snap = n_en;
        repeat (20) step();
        chk("stop_no_en", n_en - snap, 0);
        en_log.delete();
        press(1, 0, 8, 10);
        chk("resume_state", 32'(state), 1);
        chk("resume_first_en", en_log[0] + 1 - st_cyc, 10);

        // Stop then clear
        n_clr = 0;
        press(1, 0, 8, 10);
        chk("clr_stop", 32'(state), 3);
        press(0, 1, 8, 10);
        chk("clr_idle", 32'(state), 0);
        chk("clr_pulse", n_clr, 1);

        // Both keys together in RUN: start/stop wins, lap dropped
        press(1, 0, 8, 10);
        n_lap = 0;
        press(1, 1, 8, 10);
        chk("simul_state", 32'(state), 3);
        chk("simul_no_lap", n_lap, 0);

        // Overflow in LAP coinciding with the lc press event
        press(1, 0, 8, 10);
        press(0, 1, 8, 10);
        chk("ovf_in_lap", 32'(state), 2);
        snap = n_clr;
        key_lc = 1'b0;
        repeat (6) step();
        cnt_max = 1'b1;
        repeat (2) step();
        key_lc = 1'b1;
        repeat (10) step();
        chk("ovf_state", 32'(state), 3);
        chk("ovf_freeze", 32'(disp_freeze), 0);
        chk("ovf_no_clr", n_clr - snap, 0);
        snap = n_en;
        repeat (20) step();
        chk("ovf_no_en", n_en - snap, 0);

        // Reset mid-run aborts without a clear pulse
        cnt_max = 1'b0;
        press(1, 0, 8, 10);
        chk("midrst_run", 32'(state), 1);
        snap = n_clr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midrst_state", 32'(state), 0);
        chk("midrst_no_clr", n_clr - snap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
